// File: rtl/vpu_pkg.sv
// ---------------------------------------------------------------------------
// vpu_pkg
// Shared definitions for the VPU instruction path.
//   INST_W     : width of one VPU instruction word
//   OP_W       : width of the opcode field
//   OP_*       : opcode values (the issue queue forwards them without decoding)
//   inst_t     : field layout of an instruction word
//   q_state_t  : issue-queue sequencer states
// ---------------------------------------------------------------------------
package vpu_pkg;

    localparam int INST_W = 32;
    localparam int OP_W   = 4;

    // Opcodes are listed for reference by the VPU and by tools that build
    // instruction streams. OP_UNARY has no B operand.
    localparam logic [OP_W-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_W-1:0] OP_MUL   = 4'd1;
    localparam logic [OP_W-1:0] OP_UNARY = 4'd2;
    localparam logic [OP_W-1:0] OP_MAC   = 4'd3;

    // Field layout, MSB first:
    //   reserved [31:24], const [23:19], c [18:14], b [13:9], a [8:4], opcode [3:0]
    // The immediate is called cnst because const is a reserved word.
    typedef struct packed {
        logic [7:0]      reserved;
        logic [4:0]      cnst;
        logic [4:0]      c;
        logic [4:0]      b;
        logic [4:0]      a;
        logic [OP_W-1:0] opcode;
    } inst_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } q_state_t;

endpackage

// File: rtl/vpu_inst_fifo.sv
// ---------------------------------------------------------------------------
// vpu_inst_fifo
// Synchronous FIFO for VPU instruction words. Storage is a register array;
// the head entry is read combinationally, so the word at rd_ptr is visible
// in the same cycle it becomes the head.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push         : write push_data at the tail (ignored when full or flushing)
//   push_data    : word to write
//   pop          : advance the head (ignored when empty)
//   flush        : drop queued entries; applied after a same-cycle pop
//   flush_keep   : keep the current head across a flush (in-flight entry)
//   head         : word at rd_ptr (meaningless when count is 0)
//   count        : number of occupied entries
// ---------------------------------------------------------------------------
module vpu_inst_fifo
    import vpu_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int COUNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  inst_t              push_data,
    input  logic               pop,
    input  logic               flush,
    input  logic               flush_keep,
    output inst_t              head,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    inst_t              mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_next;
    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] count_next;

    logic is_full;
    logic is_empty;
    logic push_ok;
    logic pop_ok;

    assign is_full  = (count_reg == COUNT_W'(DEPTH));
    assign is_empty = (count_reg == '0);

    // A flush and a push never combine: the flushed tail position would be
    // ambiguous, so the push is dropped.
    assign push_ok = push && !flush && !is_full;
    assign pop_ok  = pop && !is_empty;

    // Pointer and occupancy update. Pointers wrap naturally because DEPTH is
    // a power of two. A keeping flush only makes sense when the head is not
    // being popped in the same cycle; if it is, the pop wins and the FIFO
    // ends up empty with wr_ptr aligned to the new head.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        if (flush) begin
            if (flush_keep && !pop_ok && !is_empty) begin
                wr_ptr_next = rd_ptr_reg + 1'b1;
                count_next  = COUNT_W'(1);
            end else begin
                wr_ptr_next = rd_ptr_next;
                count_next  = '0;
            end
        end else begin
            if (push_ok) begin
                wr_ptr_next = wr_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; entries are only ever read when counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    assign head  = mem_reg[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/vpu_issue_queue.sv
// ---------------------------------------------------------------------------
// vpu_issue_queue
// Issue stage in front of vpu_top. Buffers instruction words in a DEPTH-entry
// FIFO and launches them one at a time: a one-cycle vpu_start pulse (wired to
// the VPU mem_rdy input), then the word is held on vpu_inst until vpu_done
// retires it. The head stays in the FIFO while in flight and is popped only
// on retire, which is what keeps vpu_inst stable for the whole operation.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   in_valid   : upstream word valid
//   in_ready   : queue can accept (not full and no flush this cycle)
//   in_inst    : upstream instruction word
//   flush      : drop every queued word except the one in flight
//   vpu_inst   : head word to the VPU, 0 when the queue is empty
//   vpu_start  : one-cycle launch pulse to the VPU
//   vpu_done   : retire pulse from the VPU
//   count      : occupied entries, including the in-flight one
//   empty/full : occupancy flags
//   busy       : an instruction is being issued or is executing
//   retired    : retired-instruction counter, wraps
//   err        : sticky, set by vpu_done arriving when nothing is executing
// ---------------------------------------------------------------------------
module vpu_issue_queue
    import vpu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INST_W-1:0]            in_inst,
    input  logic                         flush,
    output logic [INST_W-1:0]            vpu_inst,
    output logic                         vpu_start,
    input  logic                         vpu_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         busy,
    output logic [CNT_W-1:0]             retired,
    output logic                         err
);

    localparam int COUNT_W = $clog2(DEPTH + 1);

    q_state_t           state_reg;
    q_state_t           state_next;
    logic [CNT_W-1:0]   retired_reg;
    logic [CNT_W-1:0]   retired_next;
    logic               err_reg;
    logic               err_next;

    logic               push;
    logic               retire;
    logic               start;
    inst_t              head;
    logic [COUNT_W-1:0] fifo_count;

    // -----------------------------------------------------------------------
    // Instruction buffer
    // -----------------------------------------------------------------------
    vpu_inst_fifo #(
        .DEPTH   (DEPTH),
        .COUNT_W (COUNT_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (inst_t'(in_inst)),
        .pop        (retire),
        .flush      (flush),
        .flush_keep (busy),
        .head       (head),
        .count      (fifo_count)
    );

    assign count    = fifo_count;
    assign empty    = (fifo_count == '0);
    assign full     = (fifo_count == COUNT_W'(DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

    assign vpu_inst = empty ? '0 : INST_W'(head);

    // -----------------------------------------------------------------------
    // Issue sequencer
    // -----------------------------------------------------------------------
    // Only a done seen in WAIT retires; anywhere else it is a protocol error
    // and leaves state and pointers alone.
    assign retire = (state_reg == WAIT) && vpu_done;
    assign busy   = (state_reg == ISSUE) || (state_reg == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ISSUE lasts exactly one cycle and is always followed by WAIT, so the
    // start pulse can never be high on two consecutive cycles. After a retire
    // the sequencer passes through IDLE for one cycle, giving the VPU time to
    // return to its own idle state before the next pulse.
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                start      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (vpu_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign vpu_start = start;

    // -----------------------------------------------------------------------
    // Retired counter and sticky error flag
    // -----------------------------------------------------------------------
    always_comb begin
        retired_next = retired_reg + CNT_W'(retire);
        err_next     = err_reg || (vpu_done && (state_reg != WAIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            retired_reg <= retired_next;
            err_reg     <= err_next;
        end
    end

    assign retired = retired_reg;
    assign err     = err_reg;

endmodule

// File: tb/tb_vpu_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_vpu_issue_queue
// Scoreboard bench: the driver issues stimulus, a negedge monitor keeps a
// queue-level model of the issue queue (list of buffered words, whether the
// head is in flight, retire count, error flag) and compares every output.
// Issued words are logged so the directed phases can also check ordering.
// ---------------------------------------------------------------------------
module tb_vpu_issue_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_inst;
    logic              flush;
    logic [31:0]       vpu_inst;
    logic              vpu_start;
    logic              vpu_done;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              busy;
    logic [CNT_W-1:0]  retired;
    logic              err;

    always #5 clk = ~clk;

    vpu_issue_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .flush     (flush),
        .vpu_inst  (vpu_inst),
        .vpu_start (vpu_start),
        .vpu_done  (vpu_done),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .busy      (busy),
        .retired   (retired),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] q[$];          // buffered words, head (possibly in flight) first
    bit          inflight;      // head launched and not yet retired
    bit          eligible_prev; // previous cycle: idle with work pending
    int          m_retired;
    bit          m_err;
    logic [31:0] issue_log[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Monitor / scoreboard
    // -----------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        bit          exp_start;
        bit          do_push;
        bit          do_retire;
        logic [31:0] head_w;
        if (rst) begin
            q.delete();
            inflight      = 1'b0;
            eligible_prev = 1'b0;
            m_retired     = 0;
            m_err         = 1'b0;
        end else begin
            // A launch follows one full cycle of being idle with work queued.
            exp_start = eligible_prev;
            chk("vpu_start", 32'(vpu_start), 32'(exp_start));
            if (exp_start) begin
                inflight = 1'b1;
                if (q.size() > 0) begin
                    issue_log.push_back(q[0]);
                    $display("[TB] issue 0x%08h at %0t", q[0], $time);
                end
            end
            chk("count",    32'(count),    32'(q.size()));
            chk("empty",    32'(empty),    32'(q.size() == 0));
            chk("full",     32'(full),     32'(q.size() == DEPTH));
            chk("busy",     32'(busy),     32'(inflight));
            chk("retired",  32'(retired),  32'(m_retired % (1 << CNT_W)));
            chk("err",      32'(err),      32'(m_err));
            chk("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !flush));
            chk("vpu_inst", vpu_inst,      (q.size() > 0) ? q[0] : 32'h0);

            eligible_prev = !inflight && (q.size() > 0);

            do_push   = in_valid && (q.size() < DEPTH) && !flush;
            do_retire = vpu_done && inflight && !exp_start;
            if (vpu_done && !do_retire) begin
                m_err = 1'b1;
            end
            if (do_retire) begin
                void'(q.pop_front());
                m_retired++;
                inflight = 1'b0;
            end
            if (flush) begin
                if (inflight && q.size() > 0) begin
                    head_w = q[0];
                    q.delete();
                    q.push_back(head_w);
                end else begin
                    q.delete();
                end
            end else if (do_push) begin
                q.push_back(in_inst);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Driver helpers (inputs change 1 time unit after the rising edge)
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit v, logic [31:0] w, bit f, bit d);
        in_valid = v;
        in_inst  = w;
        flush    = f;
        vpu_done = d;
        step();
    endtask

    task automatic wait_inflight(int budget);
        int n = 0;
        while (!inflight && n < budget) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            n++;
        end
        n_tests++;
        if (!inflight) begin
            n_fail++;
            $display("FAIL wait_issue: no vpu_start within %0d cycles", budget);
        end
    endtask

    task automatic retire_one(int delay);
        wait_inflight(20);
        repeat (delay) drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    initial begin : stim
        logic [31:0] hd;
        int          n;
        bit          v, d, f;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_inst  = 32'h0;
        flush    = 1'b0;
        vpu_done = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset values
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_vpu_inst", vpu_inst, 32'h0);
        chk("rst_count",    32'(count), 32'h0);
        chk("rst_empty",    32'(empty), 32'h1);

        // Single instruction, done held low for 5 cycles
        drive(1'b1, 32'h0000_4A13, 1'b0, 1'b0);
        wait_inflight(10);
        chk("single_inst", vpu_inst, 32'h0000_4A13);
        repeat (5) drive(1'b0, 32'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("single_retired", 32'(retired), 32'h1);
        chk("single_empty",   32'(empty),   32'h1);
        chk("single_inst0",   vpu_inst,     32'h0);
        $display("[TB] single instruction done, retired=%0d", retired);

        // Fill and drain
        issue_log.delete();
        for (int i = 1; i <= DEPTH; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h9, 1'b0, 1'b0);
        chk("fill_full",     32'(full),     32'h1);
        chk("fill_in_ready", 32'(in_ready), 32'h0);
        chk("fill_count",    32'(count),    32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) retire_one(int'($urandom_range(0, 3)));
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("drain_log_size", 32'(issue_log.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH && i < issue_log.size(); i++) begin
            chk("drain_order", issue_log[i], 32'(i + 1));
        end
        chk("drain_retired", 32'(retired), 32'h9);
        $display("[TB] fill/drain done, retired=%0d", retired);

        // Simultaneous push and retire at count 3, pointers cross 7 -> 0
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_inflight(20);
            drive(1'b1, $urandom, 1'b0, 1'b1);
            chk("pushretire_count", 32'(count), 32'h3);
        end

        // Flush while an instruction is executing
        drive(1'b1, $urandom, 1'b0, 1'b0);
        wait_inflight(20);
        hd = q[0];
        chk("preflush_count", 32'(count), 32'h4);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flush_count", 32'(count), 32'h1);
        chk("flush_head",  vpu_inst,   hd);
        retire_one(0);
        repeat (5) drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("flush_empty", 32'(empty), 32'h1);

        // Flush in the same cycle as a retire empties the queue
        drive(1'b1, $urandom, 1'b0, 1'b0);
        drive(1'b1, $urandom, 1'b0, 1'b0);
        wait_inflight(20);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        chk("flushretire_count", 32'(count), 32'h0);
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        $display("[TB] flush checks done, retired=%0d", retired);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 1) == 1);
            d = inflight && ($urandom_range(0, 3) == 0);
            f = inflight && ($urandom_range(0, 39) == 0);
            drive(v, $urandom, f, d);
        end
        n = 0;
        while ((q.size() > 0 || inflight) && n < 200) begin
            drive(1'b0, 32'h0, 1'b0, inflight);
            n++;
        end
        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("random_drained", 32'(empty), 32'h1);
        $display("[TB] random phase done, retired=%0d", retired);

        // Spurious done while idle
        hd = 32'(retired);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        chk("spurious_err",     32'(err),     32'h1);
        chk("spurious_retired", 32'(retired), hd);
        chk("spurious_count",   32'(count),   32'h0);

        do_reset();
        chk("rst2_in_ready",  32'(in_ready),  32'h1);
        chk("rst2_vpu_inst",  vpu_inst,       32'h0);
        chk("rst2_vpu_start", 32'(vpu_start), 32'h0);
        chk("rst2_count",     32'(count),     32'h0);
        chk("rst2_empty",     32'(empty),     32'h1);
        chk("rst2_full",      32'(full),      32'h0);
        chk("rst2_busy",      32'(busy),      32'h0);
        chk("rst2_retired",   32'(retired),   32'h0);
        chk("rst2_err",       32'(err),       32'h0);

        // Retired counter wraps modulo 2^CNT_W
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, $urandom, 1'b0, 1'b0);
            retire_one(0);
        end
        chk("wrap_retired", 32'(retired), 32'h1);
        $display("[TB] counter wrap done, retired=%0d", retired);

        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
